// File: rtl/node_tx_queue_if.sv
// rtl/node_tx_queue_if.sv - core-side write and router-side presentation bundle for node_tx_queue
interface node_tx_queue_if;
  logic        Core_Wr_En;
  logic [28:0] Core_Wr_Data;
  logic        Core_Full;
  logic        Core_Overflow;
  logic [28:0] Packet_From_Node;
  logic        Packet_From_Node_Valid;
  logic        Core_Load_Ack;
  logic [7:0]  Sent_Count;
  logic        Timeout_Err;

  // Queue side: takes core writes and router acks, drives status and the head packet
  modport slave (
    input  Core_Wr_En,
    input  Core_Wr_Data,
    input  Core_Load_Ack,
    output Core_Full,
    output Core_Overflow,
    output Packet_From_Node,
    output Packet_From_Node_Valid,
    output Sent_Count,
    output Timeout_Err
  );

  // Driver side: core/router model that writes packets and acknowledges the head
  modport master (
    output Core_Wr_En,
    output Core_Wr_Data,
    output Core_Load_Ack,
    input  Core_Full,
    input  Core_Overflow,
    input  Packet_From_Node,
    input  Packet_From_Node_Valid,
    input  Sent_Count,
    input  Timeout_Err
  );
endinterface

// File: rtl/node_tx_queue.sv
// rtl/node_tx_queue.sv - node transmit FIFO presenting its head to the router; optional NODE_TX_TYPE_CHECK_EN drops non-data packet types
module node_tx_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           Clk_R,
  input  logic           Rst,
  node_tx_queue_if.slave bus
);

  localparam int              PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW          = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C     = CW'(DEPTH);
  localparam logic [7:0]      STALL_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  logic [28:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic          valid_q;
  logic [28:0]   pkt_q;
  logic          ovf_q;
  logic [7:0]    sent_q;
  logic [7:0]    stall_q;
  logic          err_q;

  logic          full;
  logic          type_ok;
  logic          wr_accept;
  logic          pop;

`ifdef NODE_TX_TYPE_CHECK_EN
  // Only DATA_C (010) and DATA_3 (001) packets may enter the queue
  assign type_ok = (bus.Core_Wr_Data[28:26] == 3'b010) ||
                   (bus.Core_Wr_Data[28:26] == 3'b001);
`else
  assign type_ok = 1'b1;
`endif

  // Full is judged on the registered count, so a same-cycle pop cannot make room for a write
  always_comb begin
    full      = (count_q == DEPTH_C);
    wr_accept = bus.Core_Wr_En && !full && type_ok;
    pop       = (state_q == PRESENT) && bus.Core_Load_Ack;
    wr_ptr_d  = wr_ptr_q + PW'(wr_accept);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(wr_accept) - CW'(pop);
  end

  // Packet storage; contents beyond count are never read, so no reset is needed
  always_ff @(posedge Clk_R) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= bus.Core_Wr_Data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // One-cycle drop indication for full-queue or rejected-type writes
  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= bus.Core_Wr_En && !wr_accept;
    end
  end

  // Presentation FSM: loads the head into the output register, holds it until acked, then idles one cycle
  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      pkt_q   <= '0;
      stall_q <= '0;
      sent_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stall_q <= '0;
          if (count_q != '0) begin
            state_q <= PRESENT;
            valid_q <= 1'b1;
            pkt_q   <= mem_q[rd_ptr_q];
          end
        end
        PRESENT: begin
          if (bus.Core_Load_Ack) begin
            state_q <= GAP;
            valid_q <= 1'b0;
            pkt_q   <= '0;
            stall_q <= '0;
            if (sent_q != 8'hFF) begin
              sent_q <= sent_q + 8'd1;
            end
          end else if (stall_q < STALL_LIMIT) begin
            stall_q <= stall_q + 8'd1;
          end else begin
            // Head stays presented; the error is only reported
            err_q <= 1'b1;
          end
        end
        GAP: begin
          stall_q <= '0;
          if (count_q != '0) begin
            state_q <= PRESENT;
            valid_q <= 1'b1;
            pkt_q   <= mem_q[rd_ptr_q];
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          pkt_q   <= '0;
          stall_q <= '0;
        end
      endcase
    end
  end

  assign bus.Core_Full              = full;
  assign bus.Core_Overflow          = ovf_q;
  assign bus.Packet_From_Node       = pkt_q;
  assign bus.Packet_From_Node_Valid = valid_q;
  assign bus.Sent_Count             = sent_q;
  assign bus.Timeout_Err            = err_q;

endmodule

// File: tb/tb_node_tx_queue.sv
// tb/tb_node_tx_queue.sv - scoreboard bench for node_tx_queue: directed scenarios plus randomized traffic
module tb_node_tx_queue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;
`ifdef NODE_TX_TYPE_CHECK_EN
  localparam bit TYPE_CHECK = 1'b1;
`else
  localparam bit TYPE_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  node_tx_queue_if bus();

  node_tx_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clk_R (clk),
    .Rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [28:0] sb[$];
  int          acked = 0;
  bit          mon_en = 1'b0;
  bit          just_acked = 1'b0;
  int          zero_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit type_ok(input logic [28:0] d);
    logic [2:0] t;
    t = d[28:26];
    return !TYPE_CHECK || (t == 3'b010) || (t == 3'b001);
  endfunction

  // Monitor: compares the presented head with the scoreboard and retires it on ack
  always @(negedge clk) begin
    if (mon_en) begin
      if (just_acked) chk("gap_valid_low", {31'd0, bus.Packet_From_Node_Valid}, 32'd0);
      just_acked = 1'b0;
      if (bus.Packet_From_Node_Valid) begin
        zero_run = 0;
        chk("valid_with_queued_entry", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          chk("head_data", {3'd0, bus.Packet_From_Node}, {3'd0, sb[0]});
          if (bus.Core_Load_Ack) begin
            void'(sb.pop_front());
            acked++;
            just_acked = 1'b1;
          end
        end
      end else begin
        chk("data_zero_when_invalid", {3'd0, bus.Packet_From_Node}, 32'd0);
        if (sb.size() > 0) zero_run++;
        else zero_run = 0;
        if (zero_run > 2) begin
          chk("present_latency", zero_run, 32'd2);
          zero_run = 0;
        end
      end
    end
  end

  // One clock of stimulus; the model decides acceptance before any same-cycle pop
  task automatic cycle(input bit wr, input logic [28:0] d, input bit ack);
    bit ovf;
    ovf = 1'b0;
    if (wr) begin
      if (sb.size() < DEPTH && type_ok(d)) sb.push_back(d);
      else ovf = 1'b1;
    end
    bus.Core_Wr_En    = wr;
    bus.Core_Wr_Data  = d;
    bus.Core_Load_Ack = ack;
    @(posedge clk);
    #1;
    bus.Core_Wr_En    = 1'b0;
    bus.Core_Load_Ack = 1'b0;
    chk("overflow", {31'd0, bus.Core_Overflow}, {31'd0, ovf});
    chk("full", {31'd0, bus.Core_Full}, {31'd0, sb.size() == DEPTH});
    chk("sent_count", {24'd0, bus.Sent_Count}, (acked > 255) ? 32'd255 : acked);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 8 && !bus.Packet_From_Node_Valid; i++) cycle(1'b0, '0, 1'b0);
    chk("wait_valid", {31'd0, bus.Packet_From_Node_Valid}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) cycle(1'b0, '0, 1'b1);
    chk("drain_done", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_valid", {31'd0, bus.Packet_From_Node_Valid}, 32'd0);
    chk("rst_data", {3'd0, bus.Packet_From_Node}, 32'd0);
    chk("rst_overflow", {31'd0, bus.Core_Overflow}, 32'd0);
    chk("rst_full", {31'd0, bus.Core_Full}, 32'd0);
    chk("rst_sent", {24'd0, bus.Sent_Count}, 32'd0);
    chk("rst_timeout", {31'd0, bus.Timeout_Err}, 32'd0);
    sb.delete();
    acked = 0;
    zero_run = 0;
    just_acked = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [28:0] d;
    bus.Core_Wr_En    = 1'b0;
    bus.Core_Wr_Data  = '0;
    bus.Core_Load_Ack = 1'b0;
    #1;
    do_reset();

    // Single packet: latency, data, ack, gap, count
    cycle(1'b1, 29'h0A00_0001, 1'b0);
    chk("lat_after_write_edge", {31'd0, bus.Packet_From_Node_Valid}, 32'd0);
    cycle(1'b0, '0, 1'b0);
    chk("lat_second_edge", {31'd0, bus.Packet_From_Node_Valid}, 32'd1);
    chk("first_data", {3'd0, bus.Packet_From_Node}, 32'h0A00_0001);
    cycle(1'b0, '0, 1'b1);
    chk("valid_low_after_ack", {31'd0, bus.Packet_From_Node_Valid}, 32'd0);
    chk("sent_one", {24'd0, bus.Sent_Count}, 32'd1);
    cycle(1'b0, '0, 1'b0);
    chk("idle_after_gap", {31'd0, bus.Packet_From_Node_Valid}, 32'd0);

    // TOKEN type: dropped only when type checking is built in
    cycle(1'b1, 29'h1C00_0005, 1'b0);
    chk("token_overflow", {31'd0, bus.Core_Overflow}, {31'd0, TYPE_CHECK});
    drain();

    // Five back-to-back writes into a four-entry queue
    for (int i = 0; i < 5; i++) begin
      d = 29'h0800_0000 | (29'(i) << 22) | 29'(i + 16);
      cycle(1'b1, d, 1'b0);
      if (i == 3) chk("full_after_4th", {31'd0, bus.Core_Full}, 32'd1);
      if (i == 4) chk("overflow_on_5th", {31'd0, bus.Core_Overflow}, 32'd1);
    end

    // Write and ack together while full: write dropped, pop happens
    wait_valid();
    cycle(1'b1, 29'h0800_00AA, 1'b1);
    chk("full_write_pop_overflow", {31'd0, bus.Core_Overflow}, 32'd1);
    chk("full_cleared_by_pop", {31'd0, bus.Core_Full}, 32'd0);
    chk("remaining_three", sb.size(), 32'd3);
    drain();

    // Randomized traffic with the reference queue; long enough to saturate Sent_Count
    for (int n = 0; n < 1500; n++) begin
      d = 29'($urandom);
      cycle(($urandom % 10) < 6, d, ($urandom % 10) < 7);
    end
    chk("random_no_timeout", {31'd0, bus.Timeout_Err}, 32'd0);
    chk("sent_saturated", {24'd0, bus.Sent_Count}, (acked > 255) ? 32'd255 : acked);
    drain();

    // Reset in the middle of a presentation with three packets queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 29'h0900_0000 | 29'(i), 1'b0);
    wait_valid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    chk("post_reset_sent", {24'd0, bus.Sent_Count}, 32'd0);
    chk("post_reset_valid", {31'd0, bus.Packet_From_Node_Valid}, 32'd0);

    // Stall detection: head held TIMEOUT cycles without ack
    cycle(1'b1, 29'h0A40_0003, 1'b0);
    wait_valid();
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, '0, 1'b0);
    chk("timeout_not_yet", {31'd0, bus.Timeout_Err}, 32'd0);
    cycle(1'b0, '0, 1'b0);
    chk("timeout_set", {31'd0, bus.Timeout_Err}, 32'd1);
    chk("head_kept", {3'd0, bus.Packet_From_Node}, 32'h0A40_0003);
    cycle(1'b0, '0, 1'b1);
    chk("sent_after_timeout_ack", {24'd0, bus.Sent_Count}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0);
    chk("timeout_sticky", {31'd0, bus.Timeout_Err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/node_tx_queue.md
NODE_TX_QUEUE -- requirements
Module: node_tx_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 The module SHALL have parameter TIMEOUT, default 255, meaning the PRESENT cycles before a stall is flagged (1..255).
REQ-003 The module SHALL have port Clk_R, input, width 1: the router/node clock; all logic is on its rising edge.
REQ-004 The module SHALL have port Rst, input, width 1: asynchronous, active-high reset.
REQ-005 The module SHALL have port Core_Wr_En, input, width 1: core write strobe.
REQ-006 The module SHALL have port Core_Wr_Data, input, width 29: packet; [28:26] type, [25:22] destination address.
REQ-007 The module SHALL have port Core_Full, output, width 1: the queue holds DEPTH entries.
REQ-008 The module SHALL have port Core_Overflow, output, width 1: one-cycle pulse when a write is dropped.
REQ-009 The module SHALL have port Packet_From_Node, output, width 29: the head entry presented to the router.
REQ-010 The module SHALL have port Packet_From_Node_Valid, output, width 1: Packet_From_Node is valid.
REQ-011 The module SHALL have port Core_Load_Ack, input, width 1: router pulse meaning the head has been loaded.
REQ-012 The module SHALL have port Sent_Count, output, width 8: the saturating count of acknowledged packets.
REQ-013 The module SHALL have port Timeout_Err, output, width 1: sticky flag meaning the head was not acknowledged within TIMEOUT cycles.

Function
REQ-014 The queue SHALL be a FIFO of DEPTH x 29 bits with a read pointer, a write pointer and a count, with pointers wrapping modulo DEPTH.
REQ-015 A write with Core_Wr_En=1 and count<DEPTH SHALL be stored; with count=DEPTH it SHALL be dropped and Core_Overflow SHALL pulse for one cycle.
REQ-016 Core_Full SHALL equal (count==DEPTH), decoded from registered count.
REQ-017 The FSM SHALL have states IDLE, PRESENT and GAP.
REQ-018 In IDLE, if count>0 the FSM SHALL go to PRESENT; a write into an empty queue SHALL give Packet_From_Node_Valid=1 two cycles after the write edge.
REQ-019 In PRESENT, Packet_From_Node_Valid SHALL be 1 and Packet_From_Node SHALL equal the head entry, stable until acknowledged.
REQ-020 In PRESENT with Core_Load_Ack=1, the FSM SHALL pop the head, increment Sent_Count (saturating at 255) and go to GAP.
REQ-021 In GAP, Packet_From_Node_Valid SHALL be 0 for exactly one cycle, then the FSM SHALL go to PRESENT if count>0, else IDLE.
REQ-022 Core_Load_Ack outside PRESENT SHALL be ignored, with no pop.
REQ-023 A simultaneous write and pop when full SHALL drop the write, because full is evaluated before the pop; a simultaneous write and pop when not full SHALL perform both, leaving count unchanged.
REQ-024 A stall counter SHALL count cycles in PRESENT, clear on ack or when leaving PRESENT, and on reaching TIMEOUT SHALL set Timeout_Err, which remains set until reset; the head SHALL be kept.
REQ-025 When Packet_From_Node_Valid=0, Packet_From_Node SHALL be 29'd0.

Reset
REQ-026 Rst=1 SHALL asynchronously clear the pointers, count, stall counter, Sent_Count and Timeout_Err, and force the FSM to IDLE.
REQ-027 During reset, Packet_From_Node_Valid, Core_Overflow and Core_Full SHALL be 0 and Packet_From_Node SHALL be 0.
REQ-028 Reset asserted mid-PRESENT SHALL discard all queued packets; no ack is owed afterwards.

Configuration
REQ-029 With NODE_TX_TYPE_CHECK_EN defined, a write whose [28:26] is not 3'b010 (DATA_C) or 3'b001 (DATA_3) SHALL be dropped with a Core_Overflow pulse and leave the queue unchanged.
REQ-030 Without NODE_TX_TYPE_CHECK_EN, all types SHALL be queued.

Verification
REQ-031 Reset, then write 29'h0A00_0001 into an empty queue -> Valid=1 two cycles later, Packet_From_Node=29'h0A00_0001, ack pulse -> Valid=0 for one cycle, Sent_Count=1.
REQ-032 Write 5 packets back-to-back with DEPTH=4 and no ack -> Core_Full=1 after the 4th write, Core_Overflow pulses on the 5th, count=4.
REQ-033 Fill to 4 entries, then write and ack on the same cycle -> write dropped; after pop, Core_Full=0 and the remaining 3 entries are delivered in order.
REQ-034 Hold the head with no ack for 255 cycles -> Timeout_Err=1 and stays set; a later ack pops the head and Sent_Count increments.
REQ-035 With NODE_TX_TYPE_CHECK_EN, write type 3'b111 (TOKEN) -> Core_Overflow pulse and count remains 0; without the macro the same write is queued.
REQ-036 Assert Rst in PRESENT with 3 entries queued -> Valid=0 immediately, count=0, Sent_Count=0 after release.
